alu_pattern_applier: RTL and testbench
======================================

ALU_PATTERN_APPLIER -- requirements
Module: alu_pattern_applier

Interface
REQ-001 The block SHALL have parameter SETTLE, default 4, giving the number of clock cycles between driving the DUT inputs and strobing the DUT outputs (legal range 1..255).
REQ-002 The block SHALL have parameter PAT_W, default 16, giving the width of the pattern index and fail counters.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit: begins a test run.
REQ-006 The block SHALL have ports pat_valid (input, 1), pat_ready (output, 1), pat_pi (input, 5), pat_xpct (input, 2), pat_mask (input, 2) and pat_last (input, 1), forming the pattern stream.
REQ-007 The block SHALL have ports ain (output, 2), bin (output, 2) and sel (output, 1), which drive the ALU under test.
REQ-008 The block SHALL have port zout, input, 2 bits: the ALU response.
REQ-009 The block SHALL have status outputs busy (1), done (1), pass (1), fail_seen (1), fail_count (PAT_W) and first_fail (PAT_W).

Function
REQ-010 pat_pi SHALL map to the DUT inputs as ain = pat_pi[4:3], bin = pat_pi[2:1] and sel = pat_pi[0].
REQ-011 pat_xpct[i] and pat_mask[i] SHALL apply to zout[i]; a bit with mask 0 SHALL be ignored, and its xpct value, including X, SHALL be don't-care.
REQ-012 The FSM states SHALL be IDLE, FETCH, SETTLE, STROBE and DONE.
REQ-013 IDLE: start=1 SHALL go to FETCH and clear fail_count, first_fail, fail_seen, the pattern index and the signature.
REQ-014 FETCH: pat_ready SHALL be 1 only in this state; when pat_valid and pat_ready are both 1, the block SHALL latch pi, xpct, mask and last, drive ain, bin and sel from the next cycle, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-015 SETTLE: the counter SHALL decrement each cycle, and the block SHALL go to STROBE when it reaches 0.
REQ-016 With SETTLE=1 the FSM SHALL pass through SETTLE for exactly one cycle.
REQ-017 The handshake-to-strobe latency SHALL be SETTLE+1 cycles.
REQ-018 STROBE: zout SHALL be sampled this cycle; a mismatch is ((zout ^ xpct) & mask) != 0.
REQ-019 On a mismatch, fail_count SHALL increment, saturating at all-ones.
REQ-020 On the first mismatch of a run, first_fail SHALL receive the current pattern index and fail_seen SHALL be set to 1.
REQ-021 STROBE SHALL increment the pattern index, saturating at all-ones.
REQ-022 From STROBE the FSM SHALL go to DONE if the latched last is 1, otherwise to FETCH.
REQ-023 DONE: done SHALL be 1 and pass SHALL equal !fail_seen, both held.
REQ-024 A start=1 in DONE SHALL restart the run as from IDLE; the FSM SHALL otherwise stay in DONE.
REQ-025 start SHALL be ignored in FETCH, SETTLE and STROBE.
REQ-026 busy SHALL be 1 in FETCH, SETTLE and STROBE.
REQ-027 ain, bin and sel SHALL hold their last applied values between patterns and in DONE.
REQ-028 pat_valid without a handshake (outside FETCH) SHALL have no effect; the stream source SHALL hold its data until the handshake.
REQ-029 All outputs SHALL be driven from registers, except pat_ready, busy and pass, which SHALL decode from state and registers.

Reset
REQ-030 rst_n=0 SHALL force IDLE asynchronously at any time, including mid-run.
REQ-031 In reset, all of ain, bin, sel, done, fail_seen, fail_count, first_fail, pattern index, settle counter and signature SHALL be 0.
REQ-032 In reset, pat_ready, busy and pass SHALL be 0.
REQ-033 Release of rst_n SHALL take effect on the next rising edge; no pattern SHALL be in flight after reset.

Configuration
REQ-034 Macro ALU_PATTERN_MISR_EN defined: the block SHALL add output signature, 8 bits, a MISR with polynomial x^8+x^4+x^3+x^2+1.
REQ-035 With ALU_PATTERN_MISR_EN defined, on each STROBE the MISR SHALL shift once, XOR-ing (zout & mask) into bits [1:0], and the signature SHALL be held in DONE and cleared on start.
REQ-036 With ALU_PATTERN_MISR_EN undefined, the signature port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-037 Pass case: SETTLE=4, a single pattern pi=5'b11101, xpct=2'b10, mask=2'b11, last=1, with zout=2'b10 -> ain=2'b11, bin=2'b10, sel=1; the strobe occurs 5 cycles after the handshake; then done=1, pass=1, fail_count=0.
REQ-038 Don't-care mask: pattern pi=5'b11010, xpct=2'bX0, mask=2'b01, with zout=2'b10 and then zout=2'b00 -> no failure in either case; with zout=2'b01 -> fail_count=1, first_fail=0.
REQ-039 Multiple failures: a 6-pattern stream in which patterns 2 and 4 mismatch -> fail_count=2, first_fail=2, pass=0; pat_ready is high only in FETCH.
REQ-040 Reset mid-run: rst_n pulsed low during SETTLE of pattern 3 -> all outputs return to 0 immediately and the FSM is in IDLE; a following start runs from index 0.
REQ-041 Saturation: PAT_W=2 with 5 failing patterns -> fail_count=3 and the index saturates at 3 without wrapping.
REQ-042 MISR: with ALU_PATTERN_MISR_EN defined and the same stream run twice -> identical signature; flipping one zout bit in one pattern -> a different signature.

Source files
------------

// File: rtl/alu_pattern_applier.sv
// alu_pattern_applier: streams stimulus patterns into a 2-bit ALU, strobes zout after SETTLE cycles and tallies masked mismatches.
// Define ALU_PATTERN_MISR_EN to add the 8-bit response signature output (MISR, x^8+x^4+x^3+x^2+1).
module alu_pattern_applier #(
  parameter int SETTLE = 4,
  parameter int PAT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [4:0]       pat_pi,
  input  logic [1:0]       pat_xpct,
  input  logic [1:0]       pat_mask,
  input  logic             pat_last,
  output logic [1:0]       ain,
  output logic [1:0]       bin,
  output logic             sel,
  input  logic [1:0]       zout,
`ifdef ALU_PATTERN_MISR_EN
  output logic [7:0]       signature,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail_seen,
  output logic [PAT_W-1:0] fail_count,
  output logic [PAT_W-1:0] first_fail
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETTLE, S_STROBE, S_DONE} state_t;
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);
  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [1:0]       r_ain, r_bin, r_xpct, r_mask;
  logic             r_sel, r_last, r_done, r_fail_seen;
  logic [PAT_W-1:0] r_fail_count, r_first_fail, r_idx;
  logic [7:0]       r_sig;
  logic             w_mismatch;
  logic [7:0]       w_sig_next;
  assign w_mismatch = |((zout ^ r_xpct) & r_mask);
  // Galois form: shift left, fold the feedback through the x^4+x^3+x^2+1 taps, inject the masked response
  assign w_sig_next = {r_sig[6:0], 1'b0} ^ (r_sig[7] ? 8'h1D : 8'h00) ^ {6'b0, zout & r_mask};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ain        <= '0;
      r_bin        <= '0;
      r_sel        <= 1'b0;
      r_xpct       <= '0;
      r_mask       <= '0;
      r_last       <= 1'b0;
      r_done       <= 1'b0;
      r_fail_seen  <= 1'b0;
      r_fail_count <= '0;
      r_first_fail <= '0;
      r_idx        <= '0;
      r_sig        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state      <= S_FETCH;
            r_done       <= 1'b0;
            r_fail_seen  <= 1'b0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_idx        <= '0;
            r_sig        <= '0;
          end
        end
        S_FETCH: begin
          if (pat_valid) begin
            r_ain   <= pat_pi[4:3];
            r_bin   <= pat_pi[2:1];
            r_sel   <= pat_pi[0];
            r_xpct  <= pat_xpct;
            r_mask  <= pat_mask;
            r_last  <= pat_last;
            r_cnt   <= CNT_LOAD;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 8'd0) r_state <= S_STROBE;
          else r_cnt <= r_cnt - 8'd1;
        end
        S_STROBE: begin
          if (w_mismatch) begin
            if (!(&r_fail_count)) r_fail_count <= r_fail_count + PAT_W'(1);
            if (!r_fail_seen) begin
              r_first_fail <= r_idx;
              r_fail_seen  <= 1'b1;
            end
          end
          if (!(&r_idx)) r_idx <= r_idx + PAT_W'(1);
          r_sig   <= w_sig_next;
          r_done  <= r_last;
          r_state <= r_last ? S_DONE : S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign pat_ready  = (r_state == S_FETCH);
  assign busy       = (r_state == S_FETCH) || (r_state == S_SETTLE) || (r_state == S_STROBE);
  assign pass       = (r_state == S_DONE) && !r_fail_seen;
  assign done       = r_done;
  assign fail_seen  = r_fail_seen;
  assign fail_count = r_fail_count;
  assign first_fail = r_first_fail;
  assign ain        = r_ain;
  assign bin        = r_bin;
  assign sel        = r_sel;
`ifdef ALU_PATTERN_MISR_EN
  assign signature  = r_sig;
`else
  logic w_unused_sig;
  assign w_unused_sig = ^w_sig_next;
`endif
endmodule

// File: tb/tb_alu_pattern_applier.sv
// tb_alu_pattern_applier: scoreboard bench; A (PAT_W=16) and B (PAT_W=2) run in lockstep, C (SETTLE=1) checks minimum latency.
module tb_alu_pattern_applier;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, start, start_c, pat_valid, pat_last;
  logic [4:0] pat_pi;
  logic [1:0] pat_xpct, pat_mask, zout;
  logic a_ready, a_busy, a_done, a_pass, a_seen, a_sel;
  logic [1:0] a_ain, a_bin;
  logic [15:0] a_fc, a_ff;
  logic b_ready, b_busy, b_done, b_pass, b_seen, b_sel;
  logic [1:0] b_ain, b_bin, b_fc, b_ff;
  logic c_ready, c_busy, c_done, c_pass, c_seen, c_sel;
  logic [1:0] c_ain, c_bin;
  logic [15:0] c_fc, c_ff;
`ifdef ALU_PATTERN_MISR_EN
  logic [7:0] a_sig, b_sig, c_sig;
`endif
  alu_pattern_applier #(.SETTLE(4), .PAT_W(16)) u_a (
`ifdef ALU_PATTERN_MISR_EN
    .signature(a_sig),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(a_ready),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .ain(a_ain), .bin(a_bin), .sel(a_sel), .zout(zout), .busy(a_busy), .done(a_done),
    .pass(a_pass), .fail_seen(a_seen), .fail_count(a_fc), .first_fail(a_ff));
  alu_pattern_applier #(.SETTLE(4), .PAT_W(2)) u_b (
`ifdef ALU_PATTERN_MISR_EN
    .signature(b_sig),
`endif
    .clk(clk), .rst_n(rst_n), .start(start), .pat_valid(pat_valid), .pat_ready(b_ready),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .ain(b_ain), .bin(b_bin), .sel(b_sel), .zout(zout), .busy(b_busy), .done(b_done),
    .pass(b_pass), .fail_seen(b_seen), .fail_count(b_fc), .first_fail(b_ff));
  alu_pattern_applier #(.SETTLE(1), .PAT_W(16)) u_c (
`ifdef ALU_PATTERN_MISR_EN
    .signature(c_sig),
`endif
    .clk(clk), .rst_n(rst_n), .start(start_c), .pat_valid(pat_valid), .pat_ready(c_ready),
    .pat_pi(pat_pi), .pat_xpct(pat_xpct), .pat_mask(pat_mask), .pat_last(pat_last),
    .ain(c_ain), .bin(c_bin), .sel(c_sel), .zout(zout), .busy(c_busy), .done(c_done),
    .pass(c_pass), .fail_seen(c_seen), .fail_count(c_fc), .first_fail(c_ff));
  typedef struct {
    logic [4:0]  pi;
    logic [15:0] fc, ff;
    logic        seen;
    logic [1:0]  fcb, ffb;
  } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [15:0] m_fc, m_ff, m_idx;
  logic [1:0]  m_fcb, m_ffb, m_idxb;
  logic        m_seen;
  logic [7:0]  m_sig;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] misr(input logic [7:0] s, input logic [1:0] d);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, d};
  endfunction
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_fc = '0; m_ff = '0; m_idx = '0; m_fcb = '0; m_ffb = '0; m_idxb = '0; m_seen = 1'b0; m_sig = '0;
  endtask
  task automatic send(input logic [4:0] pi, input logic [1:0] xp, input logic [1:0] mk,
                      input logic last, input logic [1:0] z, input bit poke);
    int n;
    exp_t e;
    logic mm;
    n = 0;
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", a_ready, 1);
    pat_pi = pi; pat_xpct = xp; pat_mask = mk; pat_last = last; pat_valid = 1'b1;
    mm = |((z ^ xp) & mk);
    if (mm === 1'b1) begin
      if (m_fc != 16'hFFFF) m_fc++;
      if (m_fcb != 2'd3) m_fcb++;
      if (!m_seen) begin
        m_ff = m_idx; m_ffb = m_idxb; m_seen = 1'b1;
      end
    end
    if (m_idx != 16'hFFFF) m_idx++;
    if (m_idxb != 2'd3) m_idxb++;
    m_sig = misr(m_sig, z & mk);
    e.pi = pi; e.fc = m_fc; e.ff = m_ff; e.seen = m_seen; e.fcb = m_fcb; e.ffb = m_ffb;
    q.push_back(e);
    @(posedge clk);
    #1 pat_valid = 1'b0;
    zout = z;
    @(negedge clk);
    chk("hs_ready_busy", {a_ready, a_busy, b_ready, b_busy}, 4'b0101);
    n = 0;
    if (poke) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
    end
    while (!(a_ready || a_done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 5);
    e = q.pop_front();
    chk("applied_a", {a_ain, a_bin, a_sel}, e.pi);
    chk("applied_b", {b_ain, b_bin, b_sel}, e.pi);
    chk("fc_a", a_fc, e.fc);
    chk("ff_a", a_ff, e.ff);
    chk("seen", {a_seen, b_seen}, {e.seen, e.seen});
    chk("fc_b", b_fc, e.fcb);
    chk("ff_b", b_ff, e.ffb);
    if (last) begin
      chk("done", {a_done, a_busy, b_done, b_busy}, 4'b1010);
      chk("pass", {a_pass, b_pass}, {!e.seen, !e.seen});
`ifdef ALU_PATTERN_MISR_EN
      chk("sig", a_sig, m_sig);
`endif
    end
  endtask
  task automatic run6(input bit flip);
    do_start();
    for (int i = 0; i < 6; i++) begin
      logic [1:0] x, z;
      x = 2'(i);
      z = (i == 2 || i == 4) ? ~x : x;
      if (flip && i == 1) z[0] = ~z[0];
      send(5'(i * 5 + 3), x, 2'b11, i == 5, z, i == 3);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [4:0] held;
    int n;
`ifdef ALU_PATTERN_MISR_EN
    logic [7:0] s1;
`endif
    rst_n = 1'b0; start = 1'b0; start_c = 1'b0; pat_valid = 1'b0; pat_last = 1'b0;
    pat_pi = '0; pat_xpct = '0; pat_mask = '0; zout = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctl_a", {a_ain, a_bin, a_sel, a_done, a_seen, a_ready, a_busy, a_pass}, 0);
    chk("rst_cnt_a", {a_fc, a_ff}, 0);
    chk("rst_ctl_c", {c_ain, c_bin, c_sel, c_done, c_seen, c_ready, c_busy, c_pass}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {a_ready, a_busy, a_done}, 0);
    do_start();
    send(5'b11101, 2'b10, 2'b11, 1'b1, 2'b10, 1'b0);
    chk("pass_case", {a_ain, a_bin, a_sel, a_done, a_pass}, {5'b11101, 2'b11});
    chk("pass_fc", a_fc, 0);
    held = {a_ain, a_bin, a_sel};
    repeat (5) @(negedge clk);
    chk("done_hold", {a_ain, a_bin, a_sel, a_done, a_pass}, {held, 2'b11});
    do_start();
    send(5'b11010, 2'bx0, 2'b01, 1'b1, 2'b10, 1'b0);
    chk("dc_z10", a_fc, 0);
    do_start();
    send(5'b11010, 2'bx0, 2'b01, 1'b1, 2'b00, 1'b0);
    chk("dc_z00", a_fc, 0);
    do_start();
    send(5'b11010, 2'bx0, 2'b01, 1'b1, 2'b01, 1'b0);
    chk("dc_z01", {a_fc, a_ff}, {16'd1, 16'd0});
    run6(1'b0);
    chk("multi_fail", {a_fc, a_ff}, {16'd2, 16'd2});
    chk("multi_pass", a_pass, 0);
`ifdef ALU_PATTERN_MISR_EN
    s1 = a_sig;
    run6(1'b0);
    chk("misr_repeat", a_sig, s1);
    run6(1'b1);
    chk("misr_flip", a_sig != s1, 1);
`endif
    do_start();
    send(5'b10110, 2'b01, 2'b11, 1'b0, 2'b01, 1'b0);
    send(5'b01011, 2'b10, 2'b11, 1'b0, 2'b00, 1'b0);
    send(5'b11111, 2'b11, 2'b11, 1'b0, 2'b11, 1'b0);
    pat_pi = 5'b10101; pat_xpct = 2'b00; pat_mask = 2'b00; pat_last = 1'b0; pat_valid = 1'b1;
    @(posedge clk);
    #1 pat_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst", {a_busy, a_ain, a_bin, a_sel, a_fc[1:0]}, {1'b1, 5'b10101, 2'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_a", {a_ain, a_bin, a_sel, a_done, a_seen, a_ready, a_busy, a_pass}, 0);
    chk("rst_async_cnt", {a_fc, a_ff}, 0);
    chk("rst_async_b", {b_ain, b_bin, b_sel, b_done, b_seen, b_ready, b_busy, b_pass, b_fc, b_ff}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {a_ready, a_busy, a_done}, 0);
    do_start();
    send(5'b00100, 2'b00, 2'b11, 1'b1, 2'b10, 1'b0);
    chk("post_rst_ff", {a_fc, a_ff}, {16'd1, 16'd0});
    do_start();
    for (int i = 0; i < 5; i++) send(5'(i + 7), 2'b00, 2'b11, i == 4, 2'b11, 1'b0);
    chk("sat_fc_b", {b_fc, b_ff}, {2'd3, 2'd0});
    chk("sat_fc_a", a_fc, 5);
    do_start();
    for (int i = 0; i < 5; i++) send(5'(i + 1), 2'b01, 2'b11, i == 4, (i == 4) ? 2'b10 : 2'b01, 1'b0);
    chk("sat_idx_b", b_ff, 3);
    chk("sat_idx_a", a_ff, 4);
    held = {a_ain, a_bin, a_sel};
    @(negedge clk);
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    chk("c_ready", {c_ready, c_busy}, 2'b11);
    pat_pi = 5'b01110; pat_xpct = 2'b01; pat_mask = 2'b11; pat_last = 1'b1; pat_valid = 1'b1;
    @(posedge clk);
    #1 pat_valid = 1'b0;
    zout = 2'b01;
    @(negedge clk);
    n = 0;
    while (!c_done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("c_latency", n, 2);
    chk("c_result", {c_ain, c_bin, c_sel, c_pass, c_seen, c_busy}, {5'b01110, 3'b100});
    chk("c_counts", {c_fc, c_ff}, 0);
    chk("a_ignores_valid", {a_ain, a_bin, a_sel, a_done}, {held, 1'b1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
